// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryption controller: one round per cycle through a shared
// round datapath, with the round key expanded on the fly alongside the state.
module aes_round_sequencer (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [0:127]   plaintext,
    input  logic [0:127]   key,
    input  logic           abort,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [0:127]   ciphertext,
    output logic           busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [0:127]   st_q, st_d;
    logic [0:127]   rk_q, rk_d;
    logic [3:0]     rnd_q, rnd_d;

    logic [0:127]   rk_next_s;
    logic [0:127]   sr_s;
    logic [0:127]   mix_s;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            p  = p ^ (b[i] ? aa : 8'h00);
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254, which maps 0 to 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        logic [7:0] r;
        b = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            b = gf_mul(b, b);
            r = gf_mul(r, b);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    function automatic logic [0:127] expand_key(input logic [0:127] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, n0, n1, n2, n3;
        w0 = rk[0 +: 32];
        w1 = rk[32 +: 32];
        w2 = rk[64 +: 32];
        w3 = rk[96 +: 32];
        n0 = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Byte (row r, column c) lives at index r + 4c; row r rotates left by r columns.
    function automatic logic [0:127] sub_shift(input logic [0:127] s);
        logic [0:127] o;
        o = 128'h0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[8*(r + 4*c) +: 8] = sbox(s[8*(r + 4*((c + r) % 4)) +: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [0:127] mix_columns(input logic [0:127] s);
        logic [0:127] o;
        logic [7:0]   a0, a1, a2, a3;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c      +: 8];
            a1 = s[32*c + 8  +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            o[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    assign rk_next_s  = expand_key(rk_q, rcon(rnd_q));
    assign sr_s       = sub_shift(st_q);
    assign mix_s      = mix_columns(sr_s);
    assign ciphertext = st_q;

    // Next-state, datapath update and handshake decode.
    always_comb begin
        state_d   = state_q;
        st_d      = st_q;
        rk_d      = rk_q;
        rnd_d     = rnd_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    st_d    = plaintext ^ key;
                    rk_d    = key;
                    rnd_d   = 4'd1;
                    state_d = S_ROUND;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ROUND: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    rk_d = rk_next_s;
                    if (rnd_q == 4'd10) begin
                        st_d    = sr_s ^ rk_next_s;
                        rnd_d   = rnd_q;
                        state_d = S_DONE;
                    end else begin
                        st_d    = mix_s ^ rk_next_s;
                        rnd_d   = rnd_q + 4'd1;
                        state_d = S_ROUND;
                    end
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, round key and round counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            st_q    <= 128'h0;
            rk_q    <= 128'h0;
            rnd_q   <= 4'd1;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rk_q    <= rk_d;
            rnd_q   <= rnd_d;
        end
    end

endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Iterative AES-128 encryption controller that time-multiplexes one round datapath across all ten cipher rounds. It accepts a plaintext/key pair over a valid/ready handshake, applies the initial AddRoundKey, and runs rounds 1–9 through the `Round` datapath and round 10 through a final-round path that omits MixColumns. Round keys are expanded on the fly, one per cycle. It sits between the cipher's host-side interface and the round logic, and is the only owner of the state and round-key registers.

## Interface
- No parameters. The block is AES-128 only: 10 rounds, 128-bit key.
- `clk` input 1: single clock; all registers update on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: a plaintext/key pair is offered.
- `in_ready` output 1: the block can accept a pair. High only in IDLE.
- `plaintext` input [0:127]: input block; bit 0 is the MSB of byte 0 (FIPS-197 byte order).
- `key` input [0:127]: cipher key, same bit order.
- `abort` input 1: cancel the operation in progress.
- `out_valid` output 1: `ciphertext` is valid.
- `out_ready` input 1: the consumer accepts `ciphertext`.
- `ciphertext` output [0:127]: result, held stable while `out_valid` is high.
- `busy` output 1: high in ROUND or DONE.

## Operation
- Registers:
  - `st_q` [0:127]: cipher state.
  - `rk_q` [0:127]: current round key.
  - `rnd_q` [3:0]: round number, range 1..10.
  - FSM with states IDLE, ROUND, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: load `st_q` ← `plaintext` XOR `key`, `rk_q` ← `key`, `rnd_q` ← 1, go to ROUND.
- ROUND (one round per cycle):
  - Compute `rk_next` = expand(`rk_q`, rcon[`rnd_q`]):
    - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}
    - w1' = w1 ^ w0'
    - w2' = w2 ^ w1'
    - w3' = w3 ^ w2'
  - rcon sequence for rounds 1..10: 01,02,04,08,10,20,40,80,1b,36.
  - SubWord uses four S-box lookups, reusing the codebase S-box.
  - If `rnd_q` < 10: `st_q` ← Round(`st_q`, `rk_next`).
  - If `rnd_q` = 10: `st_q` ← AddRoundKey(ShiftRows(SubBytes(`st_q`)), `rk_next`), then go to DONE.
  - `rk_q` ← `rk_next`; `rnd_q` ← `rnd_q`+1 (not incremented past 10).
- DONE:
  - `out_valid`=1 and `ciphertext`=`st_q`.
  - On `out_ready`: go to IDLE.
  - `in_valid` is ignored in DONE.
- Abort:
  - `abort` high in ROUND or DONE forces IDLE on the next edge; `out_valid` drops and no result is produced.
  - `abort` takes priority over `out_ready` in DONE.
  - `abort` in IDLE has no effect and does not block acceptance.
- Outputs are combinational decodes of the FSM state. `ciphertext` is driven directly from `st_q`.
- Reset forces IDLE, `st_q`=0, `rk_q`=0, `rnd_q`=1 from any state, including mid-round.
  - Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `ciphertext`=0.

## Timing
- Acceptance happens at the edge where `in_valid` & `in_ready` are both high (edge A).
- Rounds 1..10 complete on edges A+1..A+10.
- `out_valid` rises in the cycle after edge A+10. Latency is 10 cycles from acceptance edge to output valid.
- Handshake completes on the edge where `out_valid` & `out_ready` are both high. `in_ready` is high in the following cycle.
- Minimum issue interval is 12 cycles with `out_ready` held at 1.
- While `out_valid`=1 and `out_ready`=0, `ciphertext` and `out_valid` hold indefinitely.
- Inputs are sampled only at the acceptance edge. Later changes to `plaintext` or `key` have no effect.
- The critical path is one Round plus one key-expansion step.

## Test plan
- FIPS-197 C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, `out_ready`=1.
  - Required: `ciphertext`=69c4e0d86a7b0430d8cdb78070b4c55a, `out_valid` rising exactly 10 cycles after acceptance.
- FIPS-197 Appendix B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734.
  - Required: ciphertext 3925841d02dc09fbdc118597196a0b32, and internal `rk_q` after round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 20 cycles after `out_valid` rises, and toggle `in_valid`/`plaintext` during that window.
  - Required: `ciphertext` stable; `in_ready`=0 throughout; exactly one handshake once `out_ready`=1.
- Back-to-back:
  - Stimulus: two C.1 requests with `in_valid` held high.
  - Required: second acceptance occurs 12 cycles after the first, and both results are correct.
- Abort at round 5:
  - Stimulus: pulse `abort` while `rnd_q`=5.
  - Required: IDLE next cycle, no `out_valid` pulse. A following Appendix B request produces the correct ciphertext.
- Reset mid-operation:
  - Stimulus: assert `rst` for 1 cycle at round 7.
  - Required: next cycle `in_ready`=1, `out_valid`=0, `busy`=0, `ciphertext`=0. A subsequent C.1 run is correct.
